fifo_rd_ctrl: RTL and testbench

Read-side controller for the project's FIFOs: it drives a FIFO read port (`fifo_rd_en`, `fifo_rd_data`, `fifo_empty`) and presents the words it reads as a valid/ready stream to a downstream consumer. A 2-entry output buffer with credit tracking hides the FIFO's 1-cycle read latency, so it sustains one word per cycle. It also provides a synchronous flush and a running count of words delivered. It sits in the `rd_clk` domain, between a FIFO and the consumer.

---
 rtl/fifo_rd_ctrl_if.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus the valid/ready output stream of the read-side controller.
// master is the controller's view; slave is the FIFO/consumer environment's view.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 1
) ();
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_rd_data,
    input  fifo_empty,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_rd_data,
    output fifo_empty,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: a 2-entry credit-tracked buffer hides the 1-cycle FIFO read
// latency and presents words as a valid/ready stream, with flush and a delivered-word count.
module fifo_rd_ctrl #(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] rd_count,
  fifo_rd_ctrl_if.master         rd_if
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e                  occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       out_valid;
  logic       pop;
  logic       arrival;
  logic       rd_en_int;
  logic [1:0] occ_num;
  logic [2:0] credit;

  always_comb begin
    out_valid = (occ_q != StEmpty);
    pop       = out_valid & rd_if.out_ready & ~flush;
    // A read issued in the previous cycle lands now unless a flush discards it.
    arrival   = pend_q & ~flush;
    unique case (occ_q)
      StOne:   occ_num = 2'd1;
      StTwo:   occ_num = 2'd2;
      default: occ_num = 2'd0;
    endcase
    // Credit counts buffered plus in-flight words after this cycle's pop.
    credit    = {1'b0, occ_num} + {2'b00, pend_q} - {2'b00, pop};
    rd_en_int = ~flush & ~rd_if.fifo_empty & (credit < 3'd2);
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    pend_d = rd_en_int;
    cnt_d  = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, pop};
    if (flush) begin
      occ_d = StEmpty;
    end else begin
      unique case (occ_q)
        StEmpty: begin
          if (arrival) begin
            occ_d  = StOne;
            head_d = rd_if.fifo_rd_data;
          end
        end
        StOne: begin
          if (arrival && !pop) begin
            occ_d  = StTwo;
            tail_d = rd_if.fifo_rd_data;
          end else if (arrival && pop) begin
            head_d = rd_if.fifo_rd_data;
          end else if (pop) begin
            occ_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            occ_d  = StOne;
            head_d = tail_q;
          end
        end
        default: occ_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q  <= StEmpty;
      pend_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Reset gates the strobe directly so a mid-cycle reset stops reads at once.
  assign rd_if.fifo_rd_en = rd_en_int & ~reset;
  assign rd_if.out_valid  = out_valid;
  assign rd_if.out_data   = head_q;
  assign rd_count         = cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO source, scoreboard queue of expected stream words,
// and a negedge monitor that pops and compares on every accepted word.
module tb_fifo_rd_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] rd_count;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .rd_count(rd_count),
    .rd_if   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency; reset empties it.
  logic [DW-1:0] src_mem [512];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr >= wr_ptr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr           <= wr_ptr;
      bus.fifo_rd_data <= '0;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= src_mem[rd_ptr];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] mdl_cnt = '0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: decoupled from stimulus, compares every accepted word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mdl_cnt = '0;
      end else begin
        if (bus.fifo_rd_en) check("rd_en_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
        if (bus.out_valid && bus.out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)",
                     bus.out_data, $time);
          end else begin
            check("stream_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            check("rd_count_at_pop", {28'd0, rd_count}, {28'd0, mdl_cnt});
            mdl_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    src_mem[wr_ptr] = w;
    wr_ptr++;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < budget) begin
      cyc();
      k++;
    end
    check(name, {31'd0, (k >= budget)}, 32'd0);
  endtask

  int          pulses;
  logic [DW-1:0] w;

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    cyc(3);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    check("reset_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("reset_rd_count", {28'd0, rd_count}, 32'd0);
    reset = 1'b0;
    cyc(2);

    // First-word latency and back-to-back streaming of A,B,C.
    bus.out_ready = 1'b1;
    load(8'h0A, 1'b1);
    load(8'h0B, 1'b1);
    load(8'h0C, 1'b1);
    #1;
    check("t1_rd_en_c0", {31'd0, bus.fifo_rd_en}, 32'd1);
    cyc();
    check("t1_valid_c1", {31'd0, bus.out_valid}, 32'd0);
    cyc();
    check("t1_valid_c2", {31'd0, bus.out_valid}, 32'd1);
    check("t1_data_c2", {24'd0, bus.out_data}, 32'h0A);
    cyc();
    check("t1_data_c3", {24'd0, bus.out_data}, 32'h0B);
    cyc();
    check("t1_data_c4", {24'd0, bus.out_data}, 32'h0C);
    cyc();
    check("t1_valid_c5", {31'd0, bus.out_valid}, 32'd0);
    check("t1_rd_count", {28'd0, rd_count}, 32'd3);
    check("t1_rd_en_idle", {31'd0, bus.fifo_rd_en}, 32'd0);

    // Back-pressure: two reads only, then a gapless burst of 8.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i), 1'b1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.fifo_rd_en) pulses++;
    end
    @(posedge clk);
    #1;
    check("t2_rd_pulses", pulses, 32'd2);
    check("t2_hold_data", {24'd0, bus.out_data}, 32'h10);
    check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_no_gap", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_done_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t2_rd_count", {28'd0, rd_count}, 32'd11);
    @(posedge clk);
    #1;

    // 200 words with pseudo-random back-pressure.
    for (int i = 0; i < 200; i++) begin
      w = 8'(i * 37 + 5);
      load(w, 1'b1);
    end
    begin
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 3000) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        cyc();
        k++;
      end
      check("t3_timeout", {31'd0, (k >= 3000)}, 32'd0);
    end
    bus.out_ready = 1'b1;
    check("t3_rd_count", {28'd0, rd_count}, 32'd3);

    // Flush with one word buffered and one in flight: only R may appear.
    bus.out_ready = 1'b0;
    load(8'hE1, 1'b0);
    load(8'hE2, 1'b0);
    load(8'hE3, 1'b1);
    cyc(2);
    check("t4_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t4_pre_head", {24'd0, bus.out_data}, 32'hE1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t4_flush_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("t4_post_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t4_count_kept", {28'd0, rd_count}, 32'd3);
    check("t4_rd_en_resume", {31'd0, bus.fifo_rd_en}, 32'd1);
    cyc();
    check("t4_inflight_dropped", {31'd0, bus.out_valid}, 32'd0);
    drain("t4_timeout", 20);
    check("t4_rd_count", {28'd0, rd_count}, 32'd4);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) load(8'h50 + 8'(i), 1'b1);
    cyc(3);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_async_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("t5_async_count", {28'd0, rd_count}, 32'd0);
    check("t5_async_data", {24'd0, bus.out_data}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc(3);
    check("t5_idle_after", {31'd0, bus.out_valid}, 32'd0);

    // 17 words from zero: counter wraps 15 -> 0 -> 1.
    for (int i = 0; i < 17; i++) load(8'hA0 + 8'(i), 1'b1);
    drain("t6_timeout", 60);
    check("t6_wrap_count", {28'd0, rd_count}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
